// File: rtl/alu_seq.sv
`default_nettype none
// ============================================================================
// Module      : alu_seq
// Description : Handshaked ALU with single-cycle logic/arith ops and
//               multi-cycle (one bit per cycle) MUL, DIVU and REMU.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       Op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Result,
  output logic             Zero,
  output logic             Cout,
  output logic             Overflow,
  output logic             DivZero
);

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_NOR  = 4'b1100;
  localparam logic [3:0] OP_MUL  = 4'b1000;
  localparam logic [3:0] OP_DIVU = 4'b1001;
  localparam logic [3:0] OP_REMU = 4'b1010;

  localparam int               CNT_W     = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [3:0]       op_q, op_d;
  // acc: product accumulator (MUL) or partial remainder (DIVU/REMU)
  logic [WIDTH-1:0] acc_q, acc_d;
  // x: shifting multiplicand (MUL) or dividend/quotient shift register (DIV)
  logic [WIDTH-1:0] x_q, x_d;
  // y: shifting multiplier (MUL) or constant divisor (DIV)
  logic [WIDTH-1:0] y_q, y_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             divz_q, divz_d;

  // Single-cycle datapath signals
  logic             is_sub;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   sum;
  logic             add_ovf;
  logic             op_legal;
  logic [WIDTH-1:0] sc_result;
  logic             sc_cout;
  logic             sc_ovf;

  // Iterative datapath signals
  logic [WIDTH-1:0] mul_acc_nxt;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH-1:0] div_diff;
  logic             div_ge;

  // Shared adder: SUB is A + ~B + 1 so Cout=1 means no borrow
  always_comb begin
    is_sub  = (Op == OP_SUB);
    b_eff   = is_sub ? ~B : B;
    sum     = {1'b0, A} + {1'b0, b_eff} + {{WIDTH{1'b0}}, is_sub};
    add_ovf = (A[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
  end

  // Result and flags of the single-cycle ops, taken straight from the inputs
  always_comb begin
    sc_result = '0;
    sc_cout   = 1'b0;
    sc_ovf    = 1'b0;
    op_legal  = 1'b1;
    case (Op)
      OP_AND: sc_result = A & B;
      OP_OR:  sc_result = A | B;
      OP_NOR: sc_result = ~(A | B);
      OP_ADD, OP_SUB: begin
        sc_result = sum[WIDTH-1:0];
        sc_cout   = sum[WIDTH];
        sc_ovf    = add_ovf;
      end
      // Direct signed compare stays correct when A - B overflows
      OP_SLT:  sc_result = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
      OP_MUL, OP_DIVU, OP_REMU: sc_result = '0;
      default: op_legal  = 1'b0;
    endcase
  end

  // One iteration of shift-add multiply and restoring divide
  always_comb begin
    mul_acc_nxt = y_q[0] ? (acc_q + x_q) : acc_q;
    div_shift   = {acc_q, x_q[WIDTH-1]};
    // Only used when div_shift >= divisor, where the difference fits WIDTH bits
    div_diff    = div_shift[WIDTH-1:0] - y_q;
    div_ge      = (div_shift >= {1'b0, y_q});
  end

  // Next-state logic for the IDLE/BUSY/DONE controller and its datapath
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    acc_d    = acc_q;
    x_d      = x_q;
    y_d      = y_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    zero_d   = zero_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    divz_d   = divz_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          op_d  = Op;
          cnt_d = '0;
          if (Op == OP_MUL || Op == OP_DIVU || Op == OP_REMU) begin
            acc_d   = '0;
            x_d     = A;
            y_d     = B;
            state_d = ST_BUSY;
          end else begin
            result_d = sc_result;
            // Unknown opcodes report every flag low, Zero included
            zero_d   = op_legal && (sc_result == '0);
            cout_d   = sc_cout;
            ovf_d    = sc_ovf;
            divz_d   = 1'b0;
            state_d  = ST_DONE;
          end
        end
      end
      ST_BUSY: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (op_q == OP_MUL) begin
          acc_d = mul_acc_nxt;
          x_d   = x_q << 1;
          y_d   = y_q >> 1;
        end else if (div_ge) begin
          acc_d = div_diff;
          x_d   = {x_q[WIDTH-2:0], 1'b1};
        end else begin
          acc_d = div_shift[WIDTH-1:0];
          x_d   = {x_q[WIDTH-2:0], 1'b0};
        end
        if (cnt_q == LAST_ITER) begin
          // A zero divisor never fails the trial subtract, so the quotient
          // naturally becomes all ones and the remainder collects A
          result_d = (op_q == OP_DIVU) ? x_d : acc_d;
          zero_d   = (result_d == '0);
          cout_d   = 1'b0;
          ovf_d    = 1'b0;
          divz_d   = (op_q != OP_MUL) && (y_q == '0);
          state_d  = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers; reset aborts any operation and clears the result
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      op_q     <= '0;
      acc_q    <= '0;
      x_q      <= '0;
      y_q      <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      zero_q   <= 1'b0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      divz_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      acc_q    <= acc_d;
      x_q      <= x_d;
      y_q      <= y_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
      divz_q   <= divz_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE) && !rst;
  assign out_valid = (state_q == ST_DONE);
  assign Result    = result_q;
  assign Zero      = zero_q;
  assign Cout      = cout_q;
  assign Overflow  = ovf_q;
  assign DivZero   = divz_q;

endmodule
`default_nettype wire
